// File: rtl/cim_mem_arbiter_pkg.sv
// Shared CiM definitions: memory-access sources, the arbiter FSM state type and
// the request bundle that every temp-result SRAM requester drives.
package cim_mem_arbiter_pkg;

  localparam int TEMP_RES_STORAGE_SIZE_CIM = 48;
  localparam int N_STORAGE                 = 12;
  localparam int MEM_ADDR_W                = 8;
  localparam int STARVE_LIMIT_DEFAULT      = 8;

  typedef enum logic [1:0] {
    MAC       = 2'd0,
    LOGIC_FSM = 2'd1,
    BUS_FSM   = 2'd2
  } mem_access_src_t;

  localparam int MEM_ACCESS_SRC_NUM = 3;
  localparam int SRC_IDX_W          = $clog2(MEM_ACCESS_SRC_NUM);

  typedef enum logic {
    ARB_NORMAL,
    ARB_FORCE
  } arb_state_t;

  // Address field is wider than the SRAM index so out-of-range requests stay visible.
  typedef struct packed {
    logic [MEM_ACCESS_SRC_NUM-1:0]                  read_req_src;
    logic [MEM_ACCESS_SRC_NUM-1:0]                  write_req_src;
    logic [MEM_ACCESS_SRC_NUM-1:0][MEM_ADDR_W-1:0] addr_table;
    logic [MEM_ACCESS_SRC_NUM-1:0][N_STORAGE-1:0]  write_data;
  } mem_access_signals_t;

  function automatic logic [SRC_IDX_W-1:0] src_index(input logic [MEM_ACCESS_SRC_NUM-1:0] onehot);
    logic [SRC_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MEM_ACCESS_SRC_NUM; i++) begin
      if (onehot[i]) idx = SRC_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/cim_prio_pick.sv
// One-hot fixed-priority selector (bit 0 wins). A non-empty force vector that
// overlaps the requests restricts the choice to the forced sources.
module cim_prio_pick #(
  parameter int N = 3
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] force_vec,
  output logic [N-1:0] pick
);

  logic [N-1:0] cand;
  logic         found;

  always_comb begin
    cand  = (|(req & force_vec)) ? (req & force_vec) : req;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (cand[i] && !found) begin
        pick[i] = 1'b1;
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cim_mem_arbiter.sv
// Single-port temp-result SRAM arbiter: fixed priority with starvation-forced
// grants, a two-stage read return pipeline and a sticky protocol-error flag.
module cim_mem_arbiter
  import cim_mem_arbiter_pkg::*;
#(
  parameter int DEPTH        = TEMP_RES_STORAGE_SIZE_CIM,
  parameter int WIDTH        = N_STORAGE,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT,
  localparam int AW          = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  mem_access_signals_t           mem_access,
  output logic [MEM_ACCESS_SRC_NUM-1:0] grant,
  output logic [MEM_ACCESS_SRC_NUM-1:0] stall,
  output logic [WIDTH-1:0]              read_data,
  output logic [MEM_ACCESS_SRC_NUM-1:0] read_data_valid,
  output logic                          sram_en,
  output logic                          sram_wen,
  output logic [AW-1:0]                 sram_addr,
  output logic [WIDTH-1:0]              sram_wdata,
  input  logic [WIDTH-1:0]              sram_rdata,
  output logic                          err
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  arb_state_t                    state;
  logic [MEM_ACCESS_SRC_NUM-1:0] force_src;
  logic [CW-1:0]                 starve_cnt [MEM_ACCESS_SRC_NUM];
  logic [MEM_ACCESS_SRC_NUM-1:0] rd_pend;

  logic [MEM_ACCESS_SRC_NUM-1:0] req;
  logic [MEM_ACCESS_SRC_NUM-1:0] force_mask;
  logic [MEM_ACCESS_SRC_NUM-1:0] pick;
  logic [MEM_ACCESS_SRC_NUM-1:0] starved;
  logic [SRC_IDX_W-1:0]          sel_idx;
  logic [MEM_ADDR_W-1:0]         sel_addr;
  logic                          sel_write;
  logic                          any_pick;
  logic                          in_range;
  logic                          read_issue;

  assign req        = mem_access.read_req_src | mem_access.write_req_src;
  assign force_mask = (state == ARB_FORCE) ? (force_src & req) : '0;

  cim_prio_pick #(
    .N(MEM_ACCESS_SRC_NUM)
  ) u_prio_pick (
    .req      (req),
    .force_vec(force_mask),
    .pick     (pick)
  );

  // A simultaneous read+write is served as a write; out-of-range grants never reach the SRAM.
  always_comb begin
    any_pick   = |pick;
    sel_idx    = src_index(pick);
    sel_addr   = mem_access.addr_table[sel_idx];
    sel_write  = mem_access.write_req_src[sel_idx];
    in_range   = 32'(sel_addr) < 32'(DEPTH);
    grant      = rst ? '0 : pick;
    stall      = rst ? '0 : (req & ~pick);
    sram_en    = !rst && any_pick && in_range;
    sram_wen   = sram_en && sel_write;
    sram_addr  = sram_en ? AW'(sel_addr) : '0;
    sram_wdata = sram_wen ? WIDTH'(mem_access.write_data[sel_idx]) : '0;
    read_issue = sram_en && !sel_write;
    for (int s = 0; s < MEM_ACCESS_SRC_NUM; s++) begin
      starved[s] = req[s] && !pick[s] && (starve_cnt[s] >= CW'(STARVE_LIMIT - 1));
    end
  end

  // Read return: grant in N, SRAM data arrives in N+1, registered for N+2.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend         <= '0;
      read_data_valid <= '0;
      read_data       <= '0;
      err             <= 1'b0;
    end else begin
      rd_pend         <= read_issue ? pick : '0;
      read_data_valid <= rd_pend;
      if (|rd_pend) read_data <= sram_rdata;
      if ((|(mem_access.read_req_src & mem_access.write_req_src)) || (any_pick && !in_range)) begin
        err <= 1'b1;
      end
    end
  end

  // Starvation counters and the force FSM; a forced grant lasts exactly one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB_NORMAL;
      force_src <= '0;
      for (int s = 0; s < MEM_ACCESS_SRC_NUM; s++) starve_cnt[s] <= '0;
    end else begin
      for (int s = 0; s < MEM_ACCESS_SRC_NUM; s++) begin
        if (!req[s] || pick[s]) begin
          starve_cnt[s] <= '0;
        end else if (starve_cnt[s] != CW'(STARVE_LIMIT)) begin
          starve_cnt[s] <= starve_cnt[s] + 1'b1;
        end
      end
      case (state)
        ARB_NORMAL: begin
          if (|starved) begin
            state     <= ARB_FORCE;
            force_src <= starved;
          end
        end
        ARB_FORCE: begin
          state     <= ARB_NORMAL;
          force_src <= '0;
        end
        default: begin
          state     <= ARB_NORMAL;
          force_src <= '0;
        end
      endcase
    end
  end

endmodule
